// File: rtl/input_conditioner.sv
// Per-bit synchroniser and tick-based debouncer for one input bank, with a change strobe.
// Define INPUT_COND_EDGE_EN to add the per-bit rise/fall pulse outputs.
`timescale 1ns/1ps

module input_conditioner #(
  parameter int               WIDTH        = 8,
  parameter int               SYNC_STAGES  = 2,
  parameter int               TICK_DIV     = 10000,
  parameter int               STABLE_TICKS = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic             changed,
  output logic             tick
`ifdef INPUT_COND_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

  // Element 0 is the newest sample; element SYNC_STAGES-1 feeds the debouncer.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  sync_s;
  logic [PW-1:0]                     presc_q, presc_d;
  logic                              tick_q, tick_d;
  logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]                  clean_q, clean_d;
  logic                              changed_q, changed_d;
`ifdef INPUT_COND_EDGE_EN
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
`endif

  assign sync_s = sync_q[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    tick_d  = (presc_q == PRESC_LAST);
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in};
    clean_d = clean_q;
    cnt_d   = cnt_q;

    for (int i = 0; i < WIDTH; i++) begin
      if (sync_s[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_q) begin
        // The count commits on the edge it would reach STABLE_TICKS, so it never stores that value.
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = sync_s[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    changed_d = |(clean_d ^ clean_q);
`ifdef INPUT_COND_EDGE_EN
    rise_d = clean_d & ~clean_q;
    fall_d = ~clean_d & clean_q;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q    <= {SYNC_STAGES{RESET_VALUE}};
      presc_q   <= '0;
      tick_q    <= 1'b0;
      cnt_q     <= '0;
      clean_q   <= RESET_VALUE;
      changed_q <= 1'b0;
`ifdef INPUT_COND_EDGE_EN
      rise_q    <= '0;
      fall_q    <= '0;
`endif
    end else begin
      sync_q    <= sync_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      changed_q <= changed_d;
`ifdef INPUT_COND_EDGE_EN
      rise_q    <= rise_d;
      fall_q    <= fall_d;
`endif
    end
  end

  assign clean_out = clean_q;
  assign changed   = changed_q;
  assign tick      = tick_q;
`ifdef INPUT_COND_EDGE_EN
  assign rise      = rise_q;
  assign fall      = fall_q;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus randomized stimulus
// compared cycle by cycle against a behavioural model of the debounce rules.
`timescale 1ns/1ps

module tb_input_conditioner;

  localparam int         WIDTH        = 8;
  localparam int         SYNC_STAGES  = 2;
  localparam int         TICK_DIV     = 4;
  localparam int         STABLE_TICKS = 3;
  localparam logic [7:0] RESET_VALUE  = 8'hFF;

  logic             clk = 1'b0;
  logic             n_rst;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clean_out;
  logic             changed;
  logic             tick;
`ifdef INPUT_COND_EDGE_EN
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
`endif

  input_conditioner #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS),
    .RESET_VALUE (RESET_VALUE)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .raw_in   (raw_in),
    .clean_out(clean_out),
    .changed  (changed),
    .tick     (tick)
`ifdef INPUT_COND_EDGE_EN
    ,
    .rise     (rise),
    .fall     (fall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: sync is the raw value seen SYNC_STAGES edges ago; a tick follows every
  // TICK_DIV-th edge since release; each bit counts ticks spent disagreeing with its output.
  logic [7:0] m_clean;
  logic [7:0] m_pipe[$];
  int         m_ticks[WIDTH];
  int         m_edges;
  logic       m_tick;
  logic       m_changed;
  logic [7:0] m_rise;
  logic [7:0] m_fall;

  task automatic model_reset();
    m_clean   = RESET_VALUE;
    m_pipe    = {};
    for (int s = 0; s < SYNC_STAGES; s++) m_pipe.push_back(RESET_VALUE);
    for (int i = 0; i < WIDTH; i++) m_ticks[i] = 0;
    m_edges   = 0;
    m_tick    = 1'b0;
    m_changed = 1'b0;
    m_rise    = '0;
    m_fall    = '0;
  endtask

  task automatic model_edge(input logic [7:0] raw);
    logic [7:0] sync_v;
    logic [7:0] next_clean;
    sync_v     = m_pipe[SYNC_STAGES-1];
    next_clean = m_clean;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_v[i] == m_clean[i]) m_ticks[i] = 0;
      else if (m_tick) begin
        m_ticks[i] = m_ticks[i] + 1;
        if (m_ticks[i] == STABLE_TICKS) begin
          next_clean[i] = sync_v[i];
          m_ticks[i]    = 0;
        end
      end
    end
    m_changed = (next_clean != m_clean);
    m_rise    = next_clean & ~m_clean;
    m_fall    = ~next_clean & m_clean;
    m_clean   = next_clean;
    m_pipe.push_front(raw);
    void'(m_pipe.pop_back());
    m_edges++;
    m_tick = (m_edges % TICK_DIV == 0);
  endtask

  task automatic compare_all();
    check("clean_out", clean_out, m_clean);
    check("changed", changed, m_changed);
    check("tick", tick, m_tick);
`ifdef INPUT_COND_EDGE_EN
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
`endif
  endtask

  // Called at a falling edge: drive, clock once, then compare at the next falling edge.
  task automatic step(input logic [7:0] v);
    raw_in = v;
    @(posedge clk);
    if (n_rst) model_edge(v);
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    for (int k = 0; k < n; k++) step(v);
  endtask

  task automatic pulse_reset(input logic [7:0] v);
    n_rst = 1'b0;
    model_reset();
    #1;
    check("rst_clean_out", clean_out, RESET_VALUE);
    check("rst_changed", changed, 1'b0);
    check("rst_tick", tick, 1'b0);
    @(negedge clk);
    step(v);
    n_rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_chg;
    int cnt_tick;
    int lat;
    bit found;
    logic chg_at;
    logic [7:0] cur;
    logic [7:0] v;
`ifdef INPUT_COND_EDGE_EN
    logic [7:0] rise_at;
    logic [7:0] fall_at;
`endif

    n_rst  = 1'b0;
    raw_in = 8'hFF;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_clean_out", clean_out, 8'hFF);
    check("reset_changed", changed, 1'b0);
    check("reset_tick", tick, 1'b0);
`ifdef INPUT_COND_EDGE_EN
    check("reset_rise", rise, 8'h00);
    check("reset_fall", fall, 8'h00);
`endif
    n_rst = 1'b1;

    // 1: idle high after reset
    cnt_chg = 0; cnt_tick = 0;
    for (int k = 0; k < 50; k++) begin
      step(8'hFF);
      cnt_chg  += int'(changed);
      cnt_tick += int'(tick);
    end
    check("idle_changed_count", cnt_chg, 0);
    check("idle_tick_count", cnt_tick, 50 / TICK_DIV);
    check("idle_clean_out", clean_out, 8'hFF);

    // 2: bit 0 held low
    found = 0; lat = 0; chg_at = 1'b0;
    for (int n = 1; n <= 20 && !found; n++) begin
      step(8'hFE);
      if (clean_out == 8'hFE) begin
        found  = 1;
        lat    = n;
        chg_at = changed;
`ifdef INPUT_COND_EDGE_EN
        rise_at = rise;
        fall_at = fall;
`endif
      end
    end
    check("bit0_found", found, 1'b1);
    check("bit0_latency_min", (lat >= SYNC_STAGES + (STABLE_TICKS - 1) * TICK_DIV + 1), 1'b1);
    check("bit0_latency_max", (lat <= SYNC_STAGES + STABLE_TICKS * TICK_DIV), 1'b1);
    check("bit0_changed_coincident", chg_at, 1'b1);
`ifdef INPUT_COND_EDGE_EN
    check("bit0_fall", fall_at, 8'h01);
    check("bit0_rise", rise_at, 8'h00);
`endif
    step(8'hFE);
    check("bit0_changed_one_cycle", changed, 1'b0);
    hold(8'hFF, 20);
    check("bit0_restored", clean_out, 8'hFF);

    // 3: short glitch on bit 3
    cnt_chg = 0;
    for (int k = 0; k < 25; k++) begin
      step((k < 5) ? 8'hF7 : 8'hFF);
      cnt_chg += int'(changed);
    end
    check("glitch_changed_count", cnt_chg, 0);
    check("glitch_clean_out", clean_out, 8'hFF);

    // 4: bouncing bit 5, then settles low
    cnt_chg = 0;
    for (int k = 0; k < 40; k++) begin
      step((((k / 3) % 2) == 0) ? 8'hDF : 8'hFF);
      cnt_chg += int'(changed);
    end
    for (int k = 0; k < 20; k++) begin
      step(8'hDF);
      cnt_chg += int'(changed);
    end
    check("bounce_changed_count", cnt_chg, 1);
    check("bounce_clean_out", clean_out, 8'hDF);
    hold(8'hFF, 20);

    // 5: four bits change together
    cnt_chg = 0;
    for (int k = 0; k < 20; k++) begin
      step(8'h3C);
      cnt_chg += int'(changed);
      if (clean_out != 8'hFF && clean_out != 8'h3C) check("multi_atomic", clean_out, 8'h3C);
    end
    check("multi_changed_count", cnt_chg, 1);
    check("multi_clean_out", clean_out, 8'h3C);
    hold(8'hFF, 20);

    // 6: reset during a count
    hold(8'hFD, 8);
    check("rst_mid_pre", clean_out, 8'hFF);
    pulse_reset(8'hFD);
    found = 0; lat = 0;
    for (int n = 1; n <= 20 && !found; n++) begin
      step(8'hFD);
      if (clean_out == 8'hFD) begin
        found = 1;
        lat   = n;
      end
    end
    check("rst_mid_found", found, 1'b1);
    check("rst_mid_latency_min", (lat >= SYNC_STAGES + (STABLE_TICKS - 1) * TICK_DIV + 1), 1'b1);
    check("rst_mid_latency_max", (lat <= SYNC_STAGES + STABLE_TICKS * TICK_DIV), 1'b1);
    hold(8'hFF, 20);

    // Randomized: level changes, single-cycle glitches and occasional resets.
    cur = 8'hFF;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) cur = 8'($urandom);
      v = cur;
      if ($urandom_range(0, 9) == 0) v = cur ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 999) == 0) pulse_reset(v);
      else step(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
